// File: rtl/parallel_to_serial_tx_pkg.sv
// rtl/parallel_to_serial_tx_pkg.sv - shared types and constants for the serial transmitter
//
// Holds the transmitter state encoding and the default word length. The
// word length is shared with the downstream 16-stage serial-to-parallel
// receiver, so both ends agree on frame size.

package parallel_to_serial_tx_pkg;

   // Word length, matching the depth of the downstream shift register.
   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

endpackage

// File: rtl/parallel_to_serial_tx.sv
// rtl/parallel_to_serial_tx.sv - parallel word in, MSB-first serial frame out
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   din         parallel word, sampled only on a handshake
//   din_valid   producer offers din
//   din_ready   block can accept a word (registered)
//   sout        serial data to the receiver D input (registered)
//   sout_en     high while sout carries a frame bit (registered)
//   frame_done  one-cycle pulse: receiver holds the complete word
//   busy        high while shifting or in the inter-frame gap

module parallel_to_serial_tx
   import parallel_to_serial_tx_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int GAP_CYCLES = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_en,
   output logic             frame_done,
   output logic             busy
);

   localparam int BW = $clog2(WIDTH);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

   state_t           state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [BW-1:0]    bitcnt, bitcnt_n;
   logic [GW-1:0]    gapcnt, gapcnt_n;
   logic             sout_n, sout_en_n, frame_done_n;
   logic             take;

   assign take = din_valid && din_ready;
   assign busy = (state != IDLE);

   // bitcnt always holds the index of the bit currently on sout. The MSB is
   // registered onto sout at the handshake edge itself so that it appears in
   // the first cycle after the handshake; shreg then keeps the remaining bits
   // left-aligned.
   always_comb begin
      state_n      = state;
      shreg_n      = shreg;
      bitcnt_n     = bitcnt;
      gapcnt_n     = gapcnt;
      sout_n       = 1'b0;
      sout_en_n    = 1'b0;
      frame_done_n = 1'b0;
      case (state)
         IDLE: begin
            if (take) begin
               state_n   = SHIFT;
               sout_n    = din[WIDTH-1];
               sout_en_n = 1'b1;
               shreg_n   = {din[WIDTH-2:0], 1'b0};
               bitcnt_n  = BIT_LAST;
            end
         end
         SHIFT: begin
            if (bitcnt != '0) begin
               sout_n    = shreg[WIDTH-1];
               sout_en_n = 1'b1;
               shreg_n   = {shreg[WIDTH-2:0], 1'b0};
               bitcnt_n  = bitcnt - 1'b1;
            end else begin
               // Bit 0 was on the link this cycle; the receiver captures it
               // on this edge, so the full word is visible next cycle.
               frame_done_n = 1'b1;
               if (GAP_CYCLES > 0) begin
                  state_n  = GAP;
                  gapcnt_n = GAP_LAST;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         GAP: begin
            if (gapcnt == '0) begin
               state_n = IDLE;
            end else begin
               gapcnt_n = gapcnt - 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         shreg      <= '0;
         bitcnt     <= '0;
         gapcnt     <= '0;
         sout       <= 1'b0;
         sout_en    <= 1'b0;
         frame_done <= 1'b0;
         din_ready  <= 1'b0;
      end else begin
         state      <= state_n;
         shreg      <= shreg_n;
         bitcnt     <= bitcnt_n;
         gapcnt     <= gapcnt_n;
         sout       <= sout_n;
         sout_en    <= sout_en_n;
         frame_done <= frame_done_n;
         din_ready  <= (state_n == IDLE);
      end
   end

endmodule

// File: tb/tb_parallel_to_serial_tx.sv
// tb/tb_parallel_to_serial_tx.sv - self-checking bench for parallel_to_serial_tx
//
// Lane 0 runs GAP_CYCLES=1, lane 1 runs GAP_CYCLES=0. Each lane has a
// frame-position model and a looped-back 16-bit receiver.

module tb_parallel_to_serial_tx;

   localparam int W = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] din [2];
   logic [1:0]  din_valid;
   logic [1:0]  din_ready_w, sout_w, sout_en_w, frame_done_w, busy_w;

   always #5 clk = ~clk;

   parallel_to_serial_tx #(.WIDTH(16), .GAP_CYCLES(1)) dut_g1 (
      .clk(clk), .reset(reset), .din(din[0]), .din_valid(din_valid[0]),
      .din_ready(din_ready_w[0]), .sout(sout_w[0]), .sout_en(sout_en_w[0]),
      .frame_done(frame_done_w[0]), .busy(busy_w[0])
   );

   parallel_to_serial_tx #(.WIDTH(16), .GAP_CYCLES(0)) dut_g0 (
      .clk(clk), .reset(reset), .din(din[1]), .din_valid(din_valid[1]),
      .din_ready(din_ready_w[1]), .sout(sout_w[1]), .sout_en(sout_en_w[1]),
      .frame_done(frame_done_w[1]), .busy(busy_w[1])
   );

   // Model: t = cycles since the last accepted word (1 = first bit cycle),
   // 0 = no word since reset; since = edges seen since reset release.
   int          t [2]       = '{0, 0};
   int          since [2]   = '{0, 0};
   int          hs_last [2] = '{0, 0};
   int          hs_prev [2] = '{0, 0};
   int          cyc         = 0;
   logic [15:0] w [2];
   logic [15:0] rx [2];
   logic [15:0] cap [2]     = '{16'h0, 16'h0};
   logic [15:0] last_rx [2] = '{16'h0, 16'h0};
   int          done_cnt [2] = '{0, 0};
   int          n_tests = 0;
   int          n_fail  = 0;

   function automatic int gap_of(input int l);
      return (l == 0) ? 1 : 0;
   endfunction

   function automatic logic model_ready(input int l);
      if (t[l] == 0) return (since[l] >= 1);
      return (t[l] >= W + gap_of(l) + 1);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int l = 0; l < 2; l++) begin
            t[l]     <= 0;
            since[l] <= 0;
         end
      end else begin
         cyc <= cyc + 1;
         for (int l = 0; l < 2; l++) begin
            rx[l] <= {rx[l][14:0], sout_w[l]};
            if (since[l] < 4) since[l] <= since[l] + 1;
            if (din_valid[l] && model_ready(l)) begin
               t[l]       <= 1;
               w[l]       <= din[l];
               hs_last[l] <= cyc;
               hs_prev[l] <= hs_last[l];
            end else if (t[l] != 0 && t[l] < 100) begin
               t[l] <= t[l] + 1;
            end
         end
      end
   end

   task automatic chk(input string name, input int l, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s lane%0d: got %0h expected %0h at %0t", name, l, act, exp, $time);
      end
   endtask

   logic e_en, e_s, e_fd, e_busy, e_rdy;

   always @(negedge clk) begin
      for (int l = 0; l < 2; l++) begin
         e_en   = (t[l] >= 1) && (t[l] <= W);
         e_s    = e_en ? w[l][W - t[l]] : 1'b0;
         e_fd   = (t[l] == W + 1);
         e_busy = (t[l] >= 1) && (t[l] <= W + gap_of(l));
         e_rdy  = model_ready(l);
         chk("sout_en", l, 32'(sout_en_w[l]), 32'(e_en));
         chk("sout", l, 32'(sout_w[l]), 32'(e_s));
         chk("frame_done", l, 32'(frame_done_w[l]), 32'(e_fd));
         chk("busy", l, 32'(busy_w[l]), 32'(e_busy));
         chk("din_ready", l, 32'(din_ready_w[l]), 32'(e_rdy));
         if (e_fd) chk("rx_word", l, 32'(rx[l]), 32'(w[l]));
         if (sout_en_w[l]) cap[l] = {cap[l][14:0], sout_w[l]};
         if (frame_done_w[l]) begin
            last_rx[l] = rx[l];
            done_cnt[l]++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_hs(input int l);
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (t[l] != 1 && n < 60);
      if (t[l] != 1) begin
         n_tests++;
         n_fail++;
         $display("FAIL handshake_timeout lane%0d: got none expected handshake within 60 cycles", l);
      end
   endtask

   task automatic send(input int l, input logic [15:0] word);
      din[l]       = word;
      din_valid[l] = 1'b1;
      wait_hs(l);
      din_valid[l] = 1'b0;
   endtask

   int d0, c0;

   initial begin
      reset     = 1'b1;
      din_valid = 2'b00;
      din[0]    = 16'h0;
      din[1]    = 16'h0;
      tick(3);
      chk("rst_din_ready", 0, 32'(din_ready_w), 32'h0);
      chk("rst_sout_en", 0, 32'(sout_en_w), 32'h0);
      chk("rst_busy", 0, 32'(busy_w), 32'h0);
      reset = 1'b0;
      tick(2);

      // Single word
      d0 = done_cnt[0];
      send(0, 16'hA5C3);
      tick(18);
      chk("a5c3_bits", 0, 32'(cap[0]), 32'h0000A5C3);
      chk("a5c3_rx", 0, 32'(last_rx[0]), 32'h0000A5C3);
      chk("a5c3_done_cnt", 0, 32'(done_cnt[0] - d0), 32'd1);

      // Back-to-back with din_valid held, gap of 1
      din[0] = 16'h0001;
      din_valid[0] = 1'b1;
      wait_hs(0);
      din[0] = 16'h8000;
      wait_hs(0);
      din_valid[0] = 1'b0;
      chk("b2b_period_g1", 0, 32'(hs_last[0] - hs_prev[0]), 32'd18);
      chk("b2b_rx_0001", 0, 32'(last_rx[0]), 32'h00000001);
      tick(18);
      chk("b2b_rx_8000", 0, 32'(last_rx[0]), 32'h00008000);

      // Back-to-back, no gap
      d0 = done_cnt[1];
      din[1] = 16'hFFFF;
      din_valid[1] = 1'b1;
      wait_hs(1);
      din[1] = 16'h0000;
      wait_hs(1);
      din_valid[1] = 1'b0;
      chk("b2b_period_g0", 1, 32'(hs_last[1] - hs_prev[1]), 32'd17);
      chk("ffff_bits", 1, 32'(cap[1]), 32'h0000FFFF);
      tick(18);
      chk("0000_bits", 1, 32'(cap[1]), 32'h00000000);
      chk("g0_done_cnt", 1, 32'(done_cnt[1] - d0), 32'd2);

      // Offer during SHIFT is ignored
      send(0, 16'hBEEF);
      tick(3);
      din[0] = 16'h1234;
      din_valid[0] = 1'b1;
      tick(1);
      din_valid[0] = 1'b0;
      tick(16);
      chk("beef_rx", 0, 32'(last_rx[0]), 32'h0000BEEF);
      chk("beef_bits", 0, 32'(cap[0]), 32'h0000BEEF);

      // Reset at cycle 7 of a frame for 2 cycles
      tick(2);
      send(0, 16'hC3A5);
      tick(6);
      d0 = done_cnt[0];
      reset = 1'b1;
      #1;
      chk("abort_sout", 0, 32'(sout_w[0]), 32'h0);
      chk("abort_sout_en", 0, 32'(sout_en_w[0]), 32'h0);
      chk("abort_busy", 0, 32'(busy_w[0]), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick(20);
      chk("abort_no_done", 0, 32'(done_cnt[0] - d0), 32'd0);
      send(0, 16'h5A5A);
      tick(18);
      chk("5a5a_rx", 0, 32'(last_rx[0]), 32'h00005A5A);

      // Release with din_valid already high
      reset = 1'b1;
      din[0] = 16'h3C3C;
      din_valid[0] = 1'b1;
      tick(2);
      reset = 1'b0;
      c0 = cyc;
      wait_hs(0);
      din_valid[0] = 1'b0;
      chk("release_hs_edge", 0, 32'(hs_last[0]), 32'(c0 + 1));
      tick(18);
      chk("3c3c_rx", 0, 32'(last_rx[0]), 32'h00003C3C);

      // Randomized traffic with occasional resets
      repeat (3000) begin
         tick(1);
         for (int l = 0; l < 2; l++) begin
            din_valid[l] = ($urandom_range(0, 2) == 0);
            din[l]       = 16'($urandom);
         end
         if ($urandom_range(0, 499) == 0) begin
            reset = 1'b1;
            tick($urandom_range(1, 3));
            reset = 1'b0;
         end
      end
      din_valid = 2'b00;
      tick(20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
